// File: rtl/train_pipe_stage.sv
// train_pipe_stage: elastic DEPTH-slot pipeline stage carrying the opaque training bundle under valid/ready
// define TRAIN_PIPE_FLUSH_EN to add a flush input that empties every slot
module train_pipe_stage #(
    parameter int size            = 3,
    parameter int data_size       = 16,
    parameter int cost_type_size  = 8,
    parameter int dense_type_size = 4,
    parameter int DEPTH           = 2,
    parameter int PAYLOAD_W       = 4*data_size*size+cost_type_size+dense_type_size+66
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PAYLOAD_W-1:0]       in_payload,
    output logic                       out_valid,
    input  logic                       out_ready,
`ifdef TRAIN_PIPE_FLUSH_EN
    input  logic                       flush,
`endif
    output logic [PAYLOAD_W-1:0]       out_payload,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int OW = $clog2(DEPTH+1);
    logic [DEPTH-1:0] v, rdy, nxt, take, v_n;
    logic [PAYLOAD_W-1:0] data [DEPTH];
    logic [PAYLOAD_W-1:0] src [DEPTH];
    logic fl;
`ifdef TRAIN_PIPE_FLUSH_EN
    assign fl = flush;
`else
    assign fl = 1'b0;
`endif
    // slot i is ready unless it and every slot downstream of it is full while the output stalls
    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            rdy[i] = out_ready || ((v | DEPTH'((1 << i) - 1)) != '1);
        nxt = DEPTH'({out_ready, rdy} >> 1);
        src[0] = in_payload;
        for (int i = 1; i < DEPTH; i++)
            src[i] = data[i-1];
        take[0] = in_valid && rdy[0] && !fl;
        for (int i = 1; i < DEPTH; i++)
            take[i] = v[i-1] && rdy[i] && !fl;
        v_n = fl ? '0 : take | (v & ~nxt);
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            v <= '0;
            for (int i = 0; i < DEPTH; i++)
                data[i] <= '0;
        end else begin
            v <= v_n;
            for (int i = 0; i < DEPTH; i++)
                if (take[i])
                    data[i] <= src[i];
        end
    assign in_ready    = rdy[0] && !fl;
    assign out_valid   = v[DEPTH-1];
    assign out_payload = data[DEPTH-1];
    assign occupancy   = OW'($countones(v));
endmodule

// File: doc/train_pipe_stage.md
Name: train_pipe_stage

Overview:
- Parametrised elastic pipeline stage for the training data path. It carries the full training-sample bundle (prediction, cost/dense type, weights, inputs, indices, update flag, pre-activation z) through DEPTH register slots.
- Adds a valid/ready handshake, stall and backpressure, and an occupancy count.
- Sits between the activation/derivative stages wherever a fixed unconditional delay cannot tolerate downstream stalls.

Parameters:
- size, 3, elements per vector field
- data_size, 16, bits per vector element
- cost_type_size, 8, cost_type field width
- dense_type_size, 4, dense_type field width
- DEPTH, 2, number of register slots; legal range 1..16
- PAYLOAD_W, 4*data_size*size+cost_type_size+dense_type_size+66, bundle width (270 at defaults); derived, not overridden

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream bundle valid
- in_ready  output  1  stage can accept a bundle this cycle
- in_payload  input  PAYLOAD_W  bundle packed MSB→LSB: predict_value, cost_type, dense_type, backprop_cost, w, x, w_layer_index[31:0], w_row_index[31:0], is_update, z
- out_valid  output  1  slot DEPTH-1 holds a bundle
- out_ready  input  1  downstream accepts
- out_payload  output  PAYLOAD_W  bundle from slot DEPTH-1, same packing as in_payload
- occupancy  output  $clog2(DEPTH+1)  number of valid slots

Behaviour:
- Slots 0..DEPTH-1; each slot has a valid bit v[i] and a PAYLOAD_W data register. Slot 0 is fed from in_payload; slot DEPTH-1 drives out_payload.
- Per-slot ready:
  - rdy[DEPTH-1] = !v[DEPTH-1] | out_ready
  - rdy[i] = !v[i] | rdy[i+1]
  - in_ready = rdy[0]. This is a combinational chain; there is no registered ready.
- Transfer rules, at each clk:
  - slot 0 loads in_payload and sets v[0] := 1 when in_valid & rdy[0]
  - slot i>0 loads slot i-1 when v[i-1] & rdy[i]
  - a slot whose content moves on and receives nothing clears its valid bit
  - data registers load only on transfer; otherwise they hold
- Latency, no stall: a bundle accepted at edge n appears on out_payload with out_valid=1 after edge n+DEPTH-1, i.e. DEPTH cycles after in_valid is sampled. Throughput is one bundle per cycle.
- Stall: with out_ready=0, slots fill from the output side. in_ready falls only when all DEPTH slots are valid. No bundle is dropped or duplicated.
- Simultaneous accept and emit when full: out_ready=1 makes rdy chain to 1, so in_ready=1 and occupancy is unchanged.
- occupancy = popcount(v), updated on the same edge as the valid bits; range 0..DEPTH.
- Every field is carried at full width, including predict_value at data_size*size bits. No truncation or sign handling; the bundle is opaque.
- in_valid with in_ready=0: the bundle is not taken. Upstream holds it; the stage does not check that it stays stable.
- Reset (rst=1, asynchronous, any time including mid-transfer):
  - all v[i]=0, all data registers=0
  - out_valid=0, out_payload=0, occupancy=0; in_ready=1 once rst is seen, since all slots are empty
  - in-flight bundles are discarded
  - release is synchronous to clk; the first accept is possible at the first edge after deassert

Optional Feature:
- Macro: TRAIN_PIPE_FLUSH_EN
- Defined:
  - adds input port flush (1 bit, after out_ready)
  - flush=1 at an edge clears all v[i] and occupancy to 0; data registers hold
  - in_ready is forced 0 while flush=1, so no accept occurs in a flush cycle and out_valid is 0 the next cycle
- Undefined: no flush port; behaviour exactly as above.

Test Plan:
- Streaming, DEPTH=2: in_valid=1 every cycle with w_row_index=0,1,2,…; out_ready=1 → out_valid first high 2 cycles after the first accept; rows emerge 0,1,2 in order, one per cycle; occupancy steady at 2.
- Backpressure, DEPTH=3: push rows 10,11,12,13 with out_ready=0 → in_ready drops after 3 accepts, occupancy=3; raise out_ready → rows 10,11,12,13 emitted in order, none lost.
- Full pass-through: full with out_ready=1 and in_valid=1 on the same cycle → in_ready=1, occupancy remains 3, output advances by one.
- Field integrity: predict_value=48'hABCD_1234_5678, cost_type=8'h5A, is_update=1, z=all-ones → out_payload bit-exact to in_payload after DEPTH cycles.
- Reset mid-stream: assert rst with occupancy=2 → out_valid=0, out_payload=0, occupancy=0 immediately, with no clock edge required; after release, the next accepted bundle is output correctly.
- TRAIN_PIPE_FLUSH_EN: occupancy=2, pulse flush one cycle with in_valid=1 → in_ready=0 during flush, occupancy=0 next cycle, flushed bundle never emitted.
